// File: rtl/key_pkg.sv
// Shared types and sizing helpers for the key-array debouncer.
package key_pkg;

  // Per-channel debounce/hold state.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } key_fsm_e;

  // Width of the mod-N counter; never narrower than one bit.
  function automatic int cnt_w(input int mod_n);
    return (mod_n <= 2) ? 1 : $clog2(mod_n);
  endfunction

  // Width of the shared per-channel timer, large enough for the longest interval.
  function automatic int timer_w(input int db, input int lng, input int rep);
    int m;
    m = db;
    if (lng > m) m = lng;
    if (rep > m) m = rep;
    return (m <= 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchroniser, debounce FSM, long-press and
// auto-repeat timing sharing a single timer.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DB_CYCLES     = 1000000,
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_state,
  output logic press_p,
  output logic release_p,
  output logic long_p,
  output logic rep_p
);

  localparam int TW = timer_w(DB_CYCLES, LONG_CYCLES, REPEAT_CYCLES);
  localparam logic [TW-1:0] DB_LAST   = TW'(DB_CYCLES - 1);
  localparam logic [TW-1:0] LONG_LAST = TW'(LONG_CYCLES - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);
  localparam logic [TW-1:0] TMR_ONE   = TW'(1);
  // Pin level that means "released"; the synchroniser resets to it so that
  // leaving reset never looks like a press.
  localparam logic REL_LVL = (ACTIVE_LOW != 0);

  logic          sync_p0;
  logic          sync_p1;
  logic          pressed;
  key_fsm_e      state;
  logic [TW-1:0] timer;
  logic          rep_ph;

  // Two-flop synchroniser for the asynchronous key pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= REL_LVL;
      sync_p1 <= REL_LVL;
    end else begin
      sync_p0 <= key_in;
      sync_p1 <= sync_p0;
    end
  end

  assign pressed = (sync_p1 != REL_LVL);

  // Debounce / hold FSM with registered level and event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      rep_ph    <= 1'b0;
      key_state <= 1'b1;
      press_p   <= 1'b0;
      release_p <= 1'b0;
      long_p    <= 1'b0;
      rep_p     <= 1'b0;
    end else begin
      press_p   <= 1'b0;
      release_p <= 1'b0;
      long_p    <= 1'b0;
      rep_p     <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (pressed) state <= PRESS_DB;
        end
        PRESS_DB: begin
          if (!pressed) begin
            state <= IDLE;
            timer <= '0;
          end else if (timer == DB_LAST) begin
            state     <= HELD;
            press_p   <= 1'b1;
            key_state <= 1'b0;
            timer     <= '0;
          end else begin
            timer <= timer + TMR_ONE;
          end
        end
        HELD: begin
          // A release wins over a timer expiry in the same cycle.
          if (!pressed) begin
            state <= RELEASE_DB;
            timer <= '0;
          end else if (!rep_ph) begin
            if (timer == LONG_LAST) begin
              long_p <= 1'b1;
              rep_ph <= 1'b1;
              timer  <= '0;
            end else begin
              timer <= timer + TMR_ONE;
            end
          end else begin
            if (timer == REP_LAST) begin
              rep_p <= 1'b1;
              timer <= '0;
            end else begin
              timer <= timer + TMR_ONE;
            end
          end
        end
        RELEASE_DB: begin
          // A bounce back to pressed keeps the repeat phase so a held key
          // continues repeating after a contact glitch.
          if (pressed) begin
            state <= HELD;
            timer <= '0;
          end else if (timer == DB_LAST) begin
            state     <= IDLE;
            release_p <= 1'b1;
            key_state <= 1'b1;
            rep_ph    <= 1'b0;
            timer     <= '0;
          end else begin
            timer <= timer + TMR_ONE;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_array_debounce_counter.sv
// Array of debounced keys; key 0 steps a mod-N counter up, key 1 steps it down.
module key_array_debounce_counter
  import key_pkg::*;
#(
  parameter int NUM_KEYS      = 3,
  parameter int DB_CYCLES     = 1000000,
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int MOD_N         = 10,
  parameter int ACTIVE_LOW    = 1,
  localparam int CNT_W        = cnt_w(MOD_N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] press_p,
  output logic [NUM_KEYS-1:0] release_p,
  output logic [NUM_KEYS-1:0] long_p,
  output logic [NUM_KEYS-1:0] rep_p,
  output logic [CNT_W-1:0]    count,
  output logic                co,
  output logic                bo
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MOD_N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic up;
  logic dn;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DB_CYCLES    (DB_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_in   (key_in[i]),
      .key_state(key_state[i]),
      .press_p  (press_p[i]),
      .release_p(release_p[i]),
      .long_p   (long_p[i]),
      .rep_p    (rep_p[i])
    );
  end

  // Long-press alone does not step the counter; only press and repeat do.
  assign up = press_p[0] | rep_p[0];
  assign dn = press_p[1] | rep_p[1];

  // Mod-N up/down counter with carry/borrow pulses aligned to the update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      co    <= 1'b0;
      bo    <= 1'b0;
    end else begin
      co <= 1'b0;
      bo <= 1'b0;
      if (up && !dn) begin
        if (count == CNT_MAX) begin
          count <= '0;
          co    <= 1'b1;
        end else begin
          count <= count + CNT_ONE;
        end
      end else if (dn && !up) begin
        if (count == '0) begin
          count <= CNT_MAX;
          bo    <= 1'b1;
        end else begin
          count <= count - CNT_ONE;
        end
      end
    end
  end

endmodule
